// File: rtl/sum_narrow_sat.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : sum_narrow_sat
// Purpose  : Narrows wide, overflow-free sums back to the datapath element
//            width. Each sum is right-shifted by SHIFT with round-half-up,
//            then saturated to OUT_WIDTH bits. Two-stage valid/ready pipeline
//            with a sticky, non-wrapping saturation event counter.
// Ports    : Clock      - system clock, rising edge
//            Reset_n    - asynchronous active-low reset
//            in_valid   - in_sum valid this cycle
//            in_ready   - block accepts in_sum this cycle
//            in_sum     - unsigned wide sum (IN_WIDTH bits)
//            out_valid  - out_data valid
//            out_ready  - downstream accepts out_data
//            out_data   - rounded, saturated result (OUT_WIDTH bits)
//            out_sat    - out_data was clipped (qualified by out_valid)
//            sat_count  - number of saturated results delivered
//            sat_clr    - synchronous clear of sat_count (has priority)
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module sum_narrow_sat #(
   parameter int IN_WIDTH  = 11,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_sum,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_sat,
   output logic [CNT_WIDTH-1:0] sat_count,
   input  logic                 sat_clr
);

   // One extra bit so that adding the rounding constant can never wrap.
   logic [IN_WIDTH:0]  rnd;
   logic [IN_WIDTH:0]  sum_ext;
   logic [IN_WIDTH:0]  scaled;

   logic               s1_valid;
   logic [IN_WIDTH:0]  s1_r;
   logic               s1_sat;
   logic [OUT_WIDTH-1:0] s1_data;

   logic               s2_load;
   logic               out_hs;
   logic               sat_inc;

   // Half an LSB of the shifted result; no rounding when nothing is shifted out.
   generate
      if (SHIFT > 0) begin : g_rnd
         assign rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
      end else begin : g_no_rnd
         assign rnd = '0;
      end
   endgenerate

   assign sum_ext = {1'b0, in_sum} + rnd;
   assign scaled  = sum_ext >> SHIFT;

   // Any set bit above the output width means the value does not fit.
   assign s1_sat  = |s1_r[IN_WIDTH:OUT_WIDTH];
   assign s1_data = s1_sat ? {OUT_WIDTH{1'b1}} : s1_r[OUT_WIDTH-1:0];

   // s2 can take new data when empty or when its current result leaves now.
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign out_hs   = out_valid && out_ready;
   assign sat_inc  = out_hs && out_sat;

   // Stage 1: rescaled value, captured on the input handshake.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (in_valid && in_ready) begin
         s1_valid <= 1'b1;
         s1_r     <= scaled;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: output register; data holds while stalled.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= s1_data;
         out_sat   <= s1_sat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturation event counter: clear wins, but a coinciding event still counts.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= sat_inc ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if (sat_inc && !(&sat_count)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sum_narrow_sat.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_sum_narrow_sat
// Purpose  : Self-checking bench for sum_narrow_sat. A behavioural model
//            (plain arithmetic plus an expected-result queue) is compared
//            against the DUT every cycle; directed sequences pin the model
//            with hand-computed values.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_sum_narrow_sat;

   localparam int IW   = 11;
   localparam int OW   = 8;
   localparam int SH   = 1;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;
   localparam int OMAX = (1 << OW) - 1;

   logic          Clock     = 1'b0;
   logic          Reset_n   = 1'b0;
   logic          in_valid  = 1'b0;
   logic [IW-1:0] in_sum    = '0;
   logic          out_ready = 1'b0;
   logic          sat_clr   = 1'b0;
   wire           in_ready;
   wire           out_valid;
   wire  [OW-1:0] out_data;
   wire           out_sat;
   wire  [CW-1:0] sat_count;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   int exp_d[$];
   int exp_s[$];
   int got_d[$];
   int got_s[$];
   int got_c[$];
   int mcnt = 0;
   bit prev_stall = 1'b0;
   int prev_d = 0;
   int prev_s = 0;

   sum_narrow_sat #(
      .IN_WIDTH (IW),
      .OUT_WIDTH(OW),
      .SHIFT    (SH),
      .CNT_WIDTH(CW)
   ) dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sum   (in_sum),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sat  (out_sat),
      .sat_count(sat_count),
      .sat_clr  (sat_clr)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Rounded, saturated value straight from the arithmetic definition.
   function automatic void model(input int s, output int d, output int sat);
      int r;
      r = (s + ((SH > 0) ? (1 << (SH - 1)) : 0)) / (1 << SH);
      if (r > OMAX) begin
         d = OMAX; sat = 1;
      end else begin
         d = r;    sat = 0;
      end
   endfunction

   // Compare process: mid-cycle, observe handshakes that occur at the next edge.
   always @(negedge Clock) begin
      int d, s, inc;
      cyc++;
      if (!Reset_n) begin
         chk("reset_out_valid", int'(out_valid), 0);
         chk("reset_sat_count", int'(sat_count), 0);
         exp_d.delete(); exp_s.delete();
         mcnt = 0;
         prev_stall = 1'b0;
      end else begin
         chk("sat_count", int'(sat_count), mcnt);
         if (prev_stall) begin
            chk("stall_data", int'(out_data), prev_d);
            chk("stall_sat", int'(out_sat), prev_s);
         end
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("out_data", int'(out_data), exp_d.pop_front());
               chk("out_sat", int'(out_sat), exp_s.pop_front());
            end
            got_d.push_back(int'(out_data));
            got_s.push_back(int'(out_sat));
            got_c.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            model(int'(in_sum), d, s);
            exp_d.push_back(d);
            exp_s.push_back(s);
         end
         inc = (out_valid && out_ready && out_sat) ? 1 : 0;
         if (sat_clr) mcnt = inc;
         else if (inc == 1 && mcnt < CMAX) mcnt++;
         prev_stall = out_valid && !out_ready;
         prev_d = int'(out_data);
         prev_s = int'(out_sat);
      end
   end

   task automatic send(input int v);
      bit hs;
      int n;
      in_valid = 1'b1;
      in_sum   = v[IW-1:0];
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 200) begin
         @(negedge Clock);
         hs = in_ready;
         @(posedge Clock); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!hs) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((exp_d.size() != 0 || out_valid) && n < 100) begin
         @(posedge Clock); #1;
         n++;
      end
      if (n >= 100) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, k, v;
      int pat[5];
      int pd[5];
      int ps[5];
      pat = '{510, 511, 2047, 3, 0};
      pd  = '{255, 255, 255, 2, 0};
      ps  = '{0, 1, 1, 0, 0};

      // Reset and first cycle after release.
      repeat (3) @(posedge Clock);
      #1 Reset_n = 1'b1;
      @(negedge Clock);
      chk("post_reset_in_ready", int'(in_ready), 1);
      chk("post_reset_out_valid", int'(out_valid), 0);
      chk("post_reset_out_data", int'(out_data), 0);
      chk("post_reset_out_sat", int'(out_sat), 0);
      @(posedge Clock); #1;

      // Single value and its latency.
      out_ready = 1'b1;
      send(116);
      k = 0;
      do begin
         @(negedge Clock);
         k++;
      end while (!out_valid && k < 10);
      chk("latency", k, 2);
      chk("first_data", int'(out_data), 58);
      chk("first_sat", int'(out_sat), 0);
      @(posedge Clock); #1;
      drain();

      // Back-to-back stream across the saturation boundary.
      base = got_d.size();
      foreach (pat[i]) send(pat[i]);
      drain();
      chk("stream_count", got_d.size() - base, 5);
      if (got_d.size() >= base + 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("stream_data", got_d[base+i], pd[i]);
            chk("stream_sat", got_s[base+i], ps[i]);
            if (i > 0) chk("stream_back_to_back", got_c[base+i] - got_c[base+i-1], 1);
         end
      end
      chk("stream_sat_count", int'(sat_count), 2);

      // Stall: both stages fill and the output holds.
      base = got_d.size();
      out_ready = 1'b0;
      send(10);
      send(20);
      in_valid = 1'b1;
      in_sum   = 30;
      repeat (3) begin
         @(negedge Clock);
         chk("stall_in_ready", int'(in_ready), 0);
         chk("stall_out_valid", int'(out_valid), 1);
         chk("stall_hold_data", int'(out_data), 5);
      end
      @(posedge Clock); #1;
      out_ready = 1'b1;
      send(30);
      drain();
      chk("stall_count", got_d.size() - base, 3);
      if (got_d.size() >= base + 3) begin
         chk("stall_out0", got_d[base], 5);
         chk("stall_out1", got_d[base+1], 10);
         chk("stall_out2", got_d[base+2], 15);
      end

      // Clear coinciding with a saturated output handshake.
      send(2047);
      @(posedge Clock); #1;
      chk("clr_handshake_valid", int'(out_valid), 1);
      sat_clr = 1'b1;
      @(posedge Clock); #1;
      sat_clr = 1'b0;
      @(negedge Clock);
      chk("clr_with_inc", int'(sat_count), 1);
      @(posedge Clock); #1;

      // Randomised traffic with random back-pressure.
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 5))
            0:       v = $urandom_range(505, 515);
            1:       v = $urandom_range(2040, 2047);
            2:       v = $urandom_range(0, 4);
            default: v = $urandom_range(0, 2047);
         endcase
         while ($urandom_range(0, 3) == 0) begin
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge Clock); #1;
         end
         in_valid = 1'b1;
         in_sum   = v[IW-1:0];
         k = 0;
         forever begin
            bit hs;
            out_ready = ($urandom_range(0, 9) < 6);
            sat_clr   = ($urandom_range(0, 49) == 0);
            @(negedge Clock);
            hs = in_ready;
            @(posedge Clock); #1;
            k++;
            if (hs || k >= 200) break;
         end
         if (k >= 200) chk("rand_send_timeout", 0, 1);
         in_valid = 1'b0;
         sat_clr  = 1'b0;
      end
      drain();
      chk("rand_queue_empty", exp_d.size(), 0);

      // Counter saturation at its maximum.
      out_ready = 1'b1;
      repeat (CMAX + 5) send(2047);
      drain();
      @(negedge Clock);
      chk("cnt_saturates", int'(sat_count), CMAX);
      @(posedge Clock); #1;

      // Reset mid-stream with both stages full.
      out_ready = 1'b0;
      send(100);
      send(200);
      in_valid = 1'b1;
      in_sum   = 300;
      @(posedge Clock); #1;
      chk("full_before_reset", int'(in_ready), 0);
      Reset_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", int'(out_valid), 0);
      chk("mid_reset_sat_count", int'(sat_count), 0);
      in_valid = 1'b0;
      @(posedge Clock);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      @(negedge Clock);
      chk("rerelease_in_ready", int'(in_ready), 1);
      chk("rerelease_out_valid", int'(out_valid), 0);
      @(posedge Clock); #1;
      base = got_d.size();
      out_ready = 1'b1;
      send(77);
      drain();
      chk("post_reset_count", got_d.size() - base, 1);
      if (got_d.size() > base) chk("post_reset_first", got_d[base], 39);

      repeat (3) @(posedge Clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
